cmp_pipe: RTL and testbench

Pipelined, parametrised magnitude comparator for streams of operand pairs. It compares two WIDTH-bit operands MSB-first, SLICE bits per stage. Each transaction can select unsigned or two's-complement signed compare. It returns one-hot equal/greater/less flags with a pass-through tag, using valid/ready handshakes on both sides. It generalises the team's fixed 4-bit combinational comparator for use in datapaths that need throughput, backpressure and signed compare.

---
 rtl/cmp_pkg.sv | 7 +
 rtl/cmp_slice.sv | 13 +
 rtl/cmp_pipe.sv | 80 ++++++++
 tb/tb_cmp_pipe.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/cmp_pkg.sv
// cmp_pkg: decision-state type and flag decode shared by the comparator pipeline
package cmp_pkg;
  typedef enum logic [1:0] {CMP_UNDEC = 2'b00, CMP_GT = 2'b01, CMP_LT = 2'b10} cmp_state_t;
  function automatic logic [2:0] cmp_flags(input cmp_state_t s);
    return s == CMP_UNDEC ? 3'b100 : s == CMP_GT ? 3'b010 : s == CMP_LT ? 3'b001 : 3'b000;
  endfunction
endpackage

// File: rtl/cmp_slice.sv
// cmp_slice: resolves one SLICE-bit slice, keeping any decision made by a higher slice
module cmp_slice
  import cmp_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a_i,
  input  logic [SLICE-1:0] b_i,
  input  logic [1:0]       st_i,
  output logic [1:0]       st_o
);
  assign st_o = st_i != CMP_UNDEC ? st_i : a_i > b_i ? CMP_GT : a_i < b_i ? CMP_LT : CMP_UNDEC;
endmodule

// File: rtl/cmp_pipe.sv
// cmp_pipe: pipelined MSB-first magnitude comparator with valid/ready handshake and tag pass-through
module cmp_pipe
  import cmp_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_signed,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             equal,
  output logic             gt,
  output logic             lt,
  output logic [TAG_W-1:0] out_tag
);
  localparam int STAGES = WIDTH / SLICE;
  localparam logic [WIDTH-1:0] MSB = WIDTH'(1) << (WIDTH - 1);
  if (WIDTH % SLICE != 0) begin : g_bad
    $error("cmp_pipe: WIDTH must be a multiple of SLICE");
  end
  logic [WIDTH-1:0] a_s [STAGES], b_s [STAGES], a_q [STAGES], b_q [STAGES];
  logic [1:0]       st_in [STAGES], st_d [STAGES], st_q [STAGES];
  logic             v_in [STAGES], v_q [STAGES];
  logic [TAG_W-1:0] tag_in [STAGES], tag_q [STAGES];
  logic             adv;
  // Operands sit left-aligned so each stage always compares the top slice of what is left.
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    if (k == 0) begin : g_in
      // Flipping both MSBs maps two's-complement order onto unsigned order.
      assign a_s[k]    = in_a ^ (in_signed ? MSB : '0);
      assign b_s[k]    = in_b ^ (in_signed ? MSB : '0);
      assign st_in[k]  = CMP_UNDEC;
      assign v_in[k]   = in_valid;
      assign tag_in[k] = in_tag;
    end else begin : g_in
      assign a_s[k]    = a_q[k-1];
      assign b_s[k]    = b_q[k-1];
      assign st_in[k]  = st_q[k-1];
      assign v_in[k]   = v_q[k-1];
      assign tag_in[k] = tag_q[k-1];
    end
    cmp_slice #(.SLICE(SLICE)) u_slice (
      .a_i (a_s[k][WIDTH-1 -: SLICE]),
      .b_i (b_s[k][WIDTH-1 -: SLICE]),
      .st_i(st_in[k]),
      .st_o(st_d[k])
    );
  end
  assign adv       = out_ready || !out_valid;
  assign in_ready  = adv;
  assign out_valid = v_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];
  assign {equal, gt, lt} = out_valid ? cmp_flags(cmp_state_t'(st_q[STAGES-1])) : 3'b000;
  // Whole pipeline moves in lockstep on adv; residuals shift out the slice just resolved.
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= 1'b0;
        st_q[k]  <= CMP_UNDEC;
        tag_q[k] <= '0;
        a_q[k]   <= '0;
        b_q[k]   <= '0;
      end
    else if (adv)
      for (int k = 0; k < STAGES; k++) begin
        v_q[k]   <= v_in[k];
        st_q[k]  <= st_d[k];
        tag_q[k] <= tag_in[k];
        a_q[k]   <= a_s[k] << SLICE;
        b_q[k]   <= b_s[k] << SLICE;
      end
endmodule

// File: tb/tb_cmp_pipe.sv
// tb_cmp_pipe: directed and randomized self-checking bench for cmp_pipe
module tb_cmp_pipe;
  localparam int WIDTH = 16, SLICE = 4, TAG_W = 4;
  logic clk = 1'b0;
  logic rst_n, in_valid, in_ready, in_signed, out_valid, out_ready, equal, gt, lt;
  logic [WIDTH-1:0] in_a, in_b;
  logic [TAG_W-1:0] in_tag, out_tag;
  int n_cmp = 0, n_bad = 0;
  logic [15:0] bp_a [8] = '{16'h0005, 16'h0003, 16'h7777, 16'h8000, 16'h8000, 16'hFFFE, 16'h1200, 16'h0010};
  logic [15:0] bp_b [8] = '{16'h0003, 16'h0005, 16'h7777, 16'h0001, 16'h0001, 16'hFFFF, 16'h1300, 16'h0001};
  logic        bp_s [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
  logic [2:0]  bp_f [8] = '{3'b010, 3'b001, 3'b100, 3'b001, 3'b010, 3'b001, 3'b001, 3'b010};
  logic [6:0]  q [$];
  logic [6:0]  held, exp_r;
  logic [15:0] ra, rb;
  logic        rs;
  int sent, got, stall, extra, w, acc, r;

  always #5 clk = ~clk;

  cmp_pipe #(.WIDTH(WIDTH), .SLICE(SLICE), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .equal(equal), .gt(gt), .lt(lt),
    .out_tag(out_tag)
  );

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  function automatic logic [2:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic g, l;
    g = s ? ($signed(a) > $signed(b)) : (a > b);
    l = s ? ($signed(a) < $signed(b)) : (a < b);
    return {!g && !l, g, l};
  endfunction

  task automatic run1(input string name, input logic [15:0] a, input logic [15:0] b,
                      input logic s, input logic [3:0] t, input logic [2:0] ef);
    int lat;
    in_a = a; in_b = b; in_signed = s; in_tag = t; in_valid = 1'b1; out_ready = 1'b1;
    #1 chk({name, "_in_ready"}, 32'(in_ready), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_latency"}, 32'(lat), 32'd4);
    chk({name, "_flags"}, 32'({equal, gt, lt}), 32'(ef));
    chk({name, "_tag"}, 32'(out_tag), 32'(t));
    @(negedge clk);
    chk({name, "_consumed"}, 32'(out_valid), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_flags", 32'({equal, gt, lt}), 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    @(negedge clk);
    run1("eq_1234", 16'h1234, 16'h1234, 1'b0, 4'd3, 3'b100);
    run1("u_8000_7fff", 16'h8000, 16'h7FFF, 1'b0, 4'd4, 3'b010);
    run1("s_8000_7fff", 16'h8000, 16'h7FFF, 1'b1, 4'd5, 3'b001);
    run1("s_ffff_0000", 16'hFFFF, 16'h0000, 1'b1, 4'd6, 3'b001);
    run1("lsb_lt", 16'hABC1, 16'hABC2, 1'b0, 4'd7, 3'b001);
    run1("lsb_gt", 16'hABC2, 16'hABC1, 1'b0, 4'd8, 3'b010);
    run1("s_eq_8000", 16'h8000, 16'h8000, 1'b1, 4'd9, 3'b100);
    run1("s_ffff_fffe", 16'hFFFF, 16'hFFFE, 1'b1, 4'd10, 3'b010);
    // backpressure: 8 back-to-back, 3-cycle stall at first result
    sent = 0; got = 0; stall = -1;
    for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
      if (out_valid && stall < 0) begin
        stall = 3;
        held = {equal, gt, lt, out_tag};
      end
      out_ready = !(stall > 0);
      in_valid = sent < 8;
      if (sent < 8) begin
        in_a = bp_a[sent]; in_b = bp_b[sent]; in_signed = bp_s[sent]; in_tag = 4'(sent);
      end
      #1;
      if (stall > 0) begin
        chk("bp_in_ready_stall", 32'(in_ready), 32'd0);
        chk("bp_held", 32'({equal, gt, lt, out_tag}), 32'(held));
        stall--;
      end else if (out_valid) begin
        chk("bp_in_ready", 32'(in_ready), 32'd1);
        chk("bp_tag", 32'(out_tag), 32'(got));
        chk("bp_flags", 32'({equal, gt, lt}), 32'(bp_f[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
      @(negedge clk);
    end
    chk("bp_count", 32'(got), 32'd8);
    in_valid = 1'b0; out_ready = 1'b1; extra = 0;
    repeat (8) begin
      #1 if (out_valid) extra++;
      @(negedge clk);
    end
    chk("bp_no_dup", 32'(extra), 32'd0);
    // reset with 3 transactions in flight
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_a = 16'(i + 1); in_b = '0; in_signed = 1'b0; in_tag = 4'(9 + i);
      @(negedge clk);
    end
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin
      @(negedge clk);
      w++;
    end
    chk("rm_first_seen", 32'(out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rm_out_valid", 32'(out_valid), 32'd0);
    chk("rm_flags", 32'({equal, gt, lt}), 32'd0);
    chk("rm_out_tag", 32'(out_tag), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    extra = 0;
    repeat (8) begin
      #1 if (out_valid) extra++;
      @(negedge clk);
    end
    chk("rm_no_stale", 32'(extra), 32'd0);
    chk("rm_in_ready", 32'(in_ready), 32'd1);
    // random traffic against a scoreboard
    acc = 0;
    for (int cyc = 0; cyc < 40000 && acc < 10000; cyc++) begin
      out_ready = $urandom_range(3) != 0;
      in_valid = $urandom_range(3) != 0;
      ra = 16'($urandom);
      r = int'($urandom_range(3));
      rb = r == 0 ? ra : r == 1 ? {ra[15:4], 4'($urandom)} : r == 2 ? {ra[15:8], 8'($urandom)} : 16'($urandom);
      rs = 1'($urandom);
      in_a = ra; in_b = rb; in_signed = rs; in_tag = 4'($urandom);
      #1;
      if (out_valid) begin
        chk("rnd_onehot", 32'($countones({equal, gt, lt})), 32'd1);
        if (out_ready) begin
          chk("rnd_expected_pending", 32'(q.size() != 0), 32'd1);
          if (q.size() != 0) begin
            exp_r = q.pop_front();
            chk("rnd_result", 32'({equal, gt, lt, out_tag}), 32'(exp_r));
          end
        end
      end else chk("rnd_idle_flags", 32'({equal, gt, lt}), 32'd0);
      if (in_valid && in_ready) begin
        q.push_back({model(ra, rb, rs), in_tag});
        acc++;
      end
      @(negedge clk);
    end
    chk("rnd_accepted", 32'(acc), 32'd10000);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) begin
      #1 if (out_valid) begin
        chk("drain_expected_pending", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          exp_r = q.pop_front();
          chk("drain_result", 32'({equal, gt, lt, out_tag}), 32'(exp_r));
        end
      end
      @(negedge clk);
    end
    chk("rnd_drained", 32'(q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
